serial_add: RTL
===============

// Module: serial_add
// PURPOSE
//  Bit-serial unsigned adder. Accepts two WIDTH-bit operands on a start pulse and adds
//    them LSB-first, one bit per clock, through a single full-adder cell built from half adders.
//  Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
//  Sits directly upstream of the half-adder cell. It sequences operand bits into the cell
//    and consumes its sum/carry outputs each cycle.
// PARAMETERS
//  WIDTH   8   operand and sum width in bits; legal range 2..32
// PORTS
//  clk     in   1      rising-edge clock; single clock domain
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A; captured on the accepted start edge
//  b       in   WIDTH  operand B; captured on the accepted start edge
//  busy    out  1      high while state != IDLE
//  done    out  1      one-cycle pulse; sum/cout valid
//  sum     out  WIDTH  registered result; holds until next done
//  cout    out  1      registered carry-out; holds until next done
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert by system):
//    - state=IDLE; busy=0, done=0, sum=0, cout=0.
//    - Internal shift registers, carry flop and bit counter all cleared.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//    - On a clk edge with start=1: a_sr<=a, b_sr<=b, s_sr<=0, c<=0, cnt<=0; go to SHIFT.
//    - With start=0: remain in IDLE.
//  SHIFT: each edge performs one bit step:
//    - s_bit = a_sr[0]^b_sr[0]^c; c <= maj(a_sr[0],b_sr[0],c).
//    - a_sr and b_sr shift right with 0 fill.
//    - s_sr <= {s_bit, s_sr[WIDTH-1:1]}; cnt <= cnt+1.
//    - On the edge where cnt==WIDTH-1: go to DONE, sum <= {s_bit, s_sr[WIDTH-1:1]}, cout <= next c.
//  DONE: done=1 for exactly this cycle; next edge returns to IDLE unconditionally.
//  Latency:
//    - start sampled at edge E0; done is high in the cycle after edge E0+WIDTH.
//    - Total of WIDTH+1 cycles from acceptance to done.
//    - Throughput: one add per WIDTH+2 cycles; start may be held high continuously.
//  Boundary conditions:
//    - start while busy (SHIFT or DONE): ignored; no queuing, and the operands are not re-captured.
//    - a/b changing after acceptance: no effect on the result.
//    - start high in the IDLE cycle right after DONE: accepted normally.
//    - Overflow: sum wraps modulo 2^WIDTH; the carry is reported only on cout.
//    - Reset mid-operation: immediate abort to the reset state; the partial result is discarded
//        and no done is issued.
//  Widths: cnt is $clog2(WIDTH) bits. All arithmetic is unsigned, with no sign extension.
// STRUCTURE
//  Shared package serial_pkg:
//    - state typedef {IDLE=2'd0, SHIFT=2'd1, DONE=2'd2}.
//    - Encoding 2'd3 is illegal and decodes to IDLE.
//  Sub-module fa_bit: combinational full adder built as two ha_df instances plus an OR for carry.
//    - Inputs a, b, cin; outputs s, co.
//    - The carry flop stays in serial_add.
//  Top level holds the FSM, counter, operand/sum shift registers and output registers.
// TESTING (WIDTH=8 unless noted)
//  1. a=8'h0F, b=8'h01, start 1 cycle -> busy for 9 cycles; done pulse at cycle 9 after accept;
//       sum=8'h10, cout=0.
//  2. a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
//  3. a=8'h00, b=8'h00 -> sum=8'h00, cout=0, done still pulses. Outputs hold after done
//       until the next done.
//  4. a=8'h12, b=8'h34 accepted; start with a=8'hFF, b=8'hFF asserted during SHIFT and
//       changing inputs -> sum=8'h46, cout=0; second request not executed.
//  5. rst_n pulled low at cycle 4 of SHIFT -> busy/done/sum/cout read 0 asynchronously;
//       no done follows. A fresh start then gives the correct result.
//  6. start held high continuously with a=8'h80, b=8'h80 -> done every 10 cycles,
//       sum=8'h00, cout=1. Repeat the sweep at WIDTH=2 and WIDTH=32 against a reference model.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the bit-serial adder.
// State encoding; 2'd3 is unused and decodes as IDLE.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// Combinational full adder from two half adders.
// Carry state lives in the caller.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  ha_df u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  ha_df u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/ha_df.sv
// Dataflow half adder cell.
// Two of these plus an OR form one full-adder bit.
module ha_df (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add.sv
// Bit-serial unsigned adder, LSB first, one bit per clock.
// Result and carry-out are registered with a one-cycle done pulse.
module serial_add
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           st_q, st_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic s_bit;
  logic c_nxt;

  fa_bit u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (c_q),
    .s   (s_bit),
    .co  (c_nxt)
  );

  always_comb begin
    st_d   = st_q;
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    s_sr_d = s_sr_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    done_d = 1'b0;
    unique case (1'b1)
      st_q == SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        s_sr_d = {s_bit, s_sr_q[WIDTH-1:1]};
        c_d    = c_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          st_d   = DONE;
          sum_d  = {s_bit, s_sr_q[WIDTH-1:1]};
          cout_d = c_nxt;
          done_d = 1'b1;
        end
      end
      st_q == DONE: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
        if (start) begin
          a_sr_d = a;
          b_sr_d = b;
          s_sr_d = '0;
          c_d    = 1'b0;
          cnt_d  = '0;
          st_d   = SHIFT;
        end
      end
    endcase
    busy_d = (st_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      a_sr_q <= '0;
      b_sr_q <= '0;
      s_sr_q <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      s_sr_q <= s_sr_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
